// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one memory port,
// one transaction in flight, data-priority with a bounded fetch-starvation count.
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT      = 1,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned MEM_BYTES    = 524288
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [63:0] d_rdata,
  output logic        d_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [3:0]  r_starve;
  logic        r_is_fetch;
  logic        r_err;
  logic        r_we;
  logic [31:0] r_if_rdata;
  logic [63:0] r_d_rdata;
  logic        w_grant_if;
  logic        w_grant_d;
  logic        w_capture;
  logic        w_d_oor;
  logic [63:0] w_d_end;

  // End address is formed in 64 bits so a top-of-range d_addr cannot wrap into range.
  assign w_d_end = {32'd0, d_addr} + 64'd7;
  assign w_d_oor = (w_d_end >= 64'(MEM_BYTES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Grants are gated by reset so all outputs drop immediately on assertion.
  always_comb begin
    w_next     = r_state;
    w_grant_if = 1'b0;
    w_grant_d  = 1'b0;
    w_capture  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!reset) begin
          if (if_req && (!d_req || (r_starve == 4'(STARVE_LIMIT)))) w_grant_if = 1'b1;
          else if (d_req)                                          w_grant_d  = 1'b1;
          if (if_req || d_req) w_next = WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == 4'(MEM_LAT)) begin
          w_capture = 1'b1;
          w_next    = RESP;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_starve   <= '0;
      r_is_fetch <= 1'b0;
      r_err      <= 1'b0;
      r_we       <= 1'b0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      if (w_grant_if) begin
        r_is_fetch <= 1'b1;
        r_err      <= 1'b0;
        r_we       <= 1'b0;
        r_starve   <= '0;
      end else if (w_grant_d) begin
        r_is_fetch <= 1'b0;
        r_err      <= w_d_oor;
        r_we       <= d_we;
        if (if_req && (r_starve != 4'(STARVE_LIMIT))) r_starve <= r_starve + 4'd1;
      end

      if (w_grant_if || w_grant_d) r_cnt <= 4'd1;
      else if (r_state == WAIT)    r_cnt <= r_cnt + 4'd1;

      if (w_capture) begin
        if (r_is_fetch)         r_if_rdata <= mem_rdata[31:0];
        else if (r_we || r_err) r_d_rdata  <= '0;
        else                    r_d_rdata  <= mem_rdata;
      end
    end
  end

  assign if_gnt    = w_grant_if;
  assign d_gnt     = w_grant_d;
  assign mem_en    = w_grant_if || (w_grant_d && !w_d_oor);
  assign mem_we    = w_grant_d && !w_d_oor && d_we;
  assign mem_addr  = w_grant_if ? if_addr : (w_grant_d ? {32'd0, d_addr} : '0);
  assign mem_wdata = w_grant_d ? d_wdata : '0;

  assign if_rvalid = (r_state == RESP) && r_is_fetch;
  assign d_rvalid  = (r_state == RESP) && !r_is_fetch;
  assign d_err     = d_rvalid && r_err;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MEM_LAT=1 main instance, MEM_LAT=3 instance for hold-off.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [63:0] if_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic [31:0] d_addr = '0;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, d_err, mem_en, mem_we, busy;
  logic [31:0] if_rdata;
  logic [63:0] d_rdata, mem_addr, mem_wdata;

  logic        x_if_req = 1'b0, x_d_req = 1'b0;
  logic        x_if_gnt, x_if_rvalid, x_d_gnt, x_d_rvalid, x_d_err, x_mem_en, x_mem_we, x_busy;
  logic [31:0] x_if_rdata;
  logic [63:0] x_d_rdata, x_mem_addr, x_mem_wdata;

  mem_port_arbiter #(.MEM_LAT(1), .STARVE_LIMIT(4), .MEM_BYTES(524288)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.MEM_LAT(3), .STARVE_LIMIT(4), .MEM_BYTES(524288)) u_dut3 (
    .clk(clk), .reset(reset),
    .if_req(x_if_req), .if_addr(64'h40), .if_gnt(x_if_gnt), .if_rvalid(x_if_rvalid), .if_rdata(x_if_rdata),
    .d_req(x_d_req), .d_we(1'b0), .d_addr(32'h80), .d_wdata(64'd0),
    .d_gnt(x_d_gnt), .d_rvalid(x_d_rvalid), .d_rdata(x_d_rdata), .d_err(x_d_err),
    .mem_en(x_mem_en), .mem_we(x_mem_we), .mem_addr(x_mem_addr), .mem_wdata(x_mem_wdata),
    .mem_rdata(64'h1111_2222_3333_4444), .busy(x_busy)
  );

  task test_reset();
    #1;
    n_tests++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL rst_busy: got %h expected 0", busy); end
    n_tests++; if (if_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_if_rvalid: got %h expected 0", if_rvalid); end
    n_tests++; if (d_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_d_rvalid: got %h expected 0", d_rvalid); end
    n_tests++; if (mem_en !== 1'b0)   begin n_fail++; $display("FAIL rst_mem_en: got %h expected 0", mem_en); end
    n_tests++; if (d_rdata !== 64'd0) begin n_fail++; $display("FAIL rst_d_rdata: got %h expected 0", d_rdata); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task test_fetch();
    @(negedge clk);
    if_req = 1'b1; if_addr = 64'h2000; mem_rdata = 64'hDEADBEEF_12345678;
    #1;
    n_tests++; if (if_gnt !== 1'b1)         begin n_fail++; $display("FAIL fetch_gnt: got %h expected 1", if_gnt); end
    n_tests++; if (d_gnt !== 1'b0)          begin n_fail++; $display("FAIL fetch_dgnt: got %h expected 0", d_gnt); end
    n_tests++; if (mem_en !== 1'b1)         begin n_fail++; $display("FAIL fetch_mem_en: got %h expected 1", mem_en); end
    n_tests++; if (mem_we !== 1'b0)         begin n_fail++; $display("FAIL fetch_mem_we: got %h expected 0", mem_we); end
    n_tests++; if (mem_addr !== 64'h2000)   begin n_fail++; $display("FAIL fetch_mem_addr: got %h expected 2000", mem_addr); end
    @(negedge clk);
    if_req = 1'b0;
    #1;
    n_tests++; if (busy !== 1'b1)           begin n_fail++; $display("FAIL fetch_busy: got %h expected 1", busy); end
    n_tests++; if (mem_en !== 1'b0)         begin n_fail++; $display("FAIL fetch_mem_en_wait: got %h expected 0", mem_en); end
    n_tests++; if (if_rvalid !== 1'b0)      begin n_fail++; $display("FAIL fetch_rvalid_early: got %h expected 0", if_rvalid); end
    @(negedge clk); #1;
    n_tests++; if (if_rvalid !== 1'b1)      begin n_fail++; $display("FAIL fetch_rvalid: got %h expected 1", if_rvalid); end
    n_tests++; if (if_rdata !== 32'h12345678) begin n_fail++; $display("FAIL fetch_rdata: got %h expected 12345678", if_rdata); end
    n_tests++; if (d_rvalid !== 1'b0)       begin n_fail++; $display("FAIL fetch_d_rvalid: got %h expected 0", d_rvalid); end
    @(negedge clk); #1;
    n_tests++; if (if_rvalid !== 1'b0)      begin n_fail++; $display("FAIL fetch_rvalid_pulse: got %h expected 0", if_rvalid); end
    n_tests++; if (busy !== 1'b0)           begin n_fail++; $display("FAIL fetch_idle: got %h expected 0", busy); end
    n_tests++; if (if_rdata !== 32'h12345678) begin n_fail++; $display("FAIL fetch_rdata_hold: got %h expected 12345678", if_rdata); end
  endtask

  task test_starve();
    logic [9:0] exp_if;
    logic       got_if;
    bit         found;
    exp_if = 10'b10_0001_0000;
    @(negedge clk);
    if_req = 1'b1; if_addr = 64'h2000; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    for (int g = 0; g < 10; g++) begin
      found = 1'b0; got_if = 1'b0;
      for (int c = 0; c < 8 && !found; c++) begin
        if (c != 0 || g != 0) @(negedge clk);
        #1;
        if (if_gnt || d_gnt) begin found = 1'b1; got_if = if_gnt; end
      end
      n_tests++;
      if (!found) begin n_fail++; $display("FAIL starve_timeout: grant %0d got none expected %0d", g, exp_if[g]); end
      else if (got_if !== exp_if[g]) begin n_fail++; $display("FAIL starve_seq: grant %0d got if=%0d expected if=%0d", g, got_if, exp_if[g]); end
    end
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0;
    for (int c = 0; c < 8 && busy; c++) @(negedge clk);
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL starve_idle: got %h expected 0", busy); end
  endtask

  task test_store();
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 64'h0123456789ABCDEF; mem_rdata = 64'hDEADBEEF_12345678;
    #1;
    n_tests++; if (d_gnt !== 1'b1)       begin n_fail++; $display("FAIL store_gnt: got %h expected 1", d_gnt); end
    n_tests++; if (mem_en !== 1'b1)      begin n_fail++; $display("FAIL store_mem_en: got %h expected 1", mem_en); end
    n_tests++; if (mem_we !== 1'b1)      begin n_fail++; $display("FAIL store_mem_we: got %h expected 1", mem_we); end
    n_tests++; if (mem_addr !== 64'h100) begin n_fail++; $display("FAIL store_mem_addr: got %h expected 100", mem_addr); end
    n_tests++; if (mem_wdata !== 64'h0123456789ABCDEF) begin n_fail++; $display("FAIL store_wdata: got %h expected 0123456789abcdef", mem_wdata); end
    @(negedge clk);
    d_req = 1'b0; d_we = 1'b0;
    #1;
    n_tests++; if (mem_we !== 1'b0)      begin n_fail++; $display("FAIL store_we_wait: got %h expected 0", mem_we); end
    @(negedge clk); #1;
    n_tests++; if (d_rvalid !== 1'b1)    begin n_fail++; $display("FAIL store_rvalid: got %h expected 1", d_rvalid); end
    n_tests++; if (d_rdata !== 64'd0)    begin n_fail++; $display("FAIL store_rdata: got %h expected 0", d_rdata); end
    n_tests++; if (d_err !== 1'b0)       begin n_fail++; $display("FAIL store_err: got %h expected 0", d_err); end
    @(negedge clk); #1;
  endtask

  task test_load_boundary();
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h7FFF8; mem_rdata = 64'hA5A5_0000_FFFF_1234;
    #1;
    n_tests++; if (mem_en !== 1'b1) begin n_fail++; $display("FAIL load_mem_en: got %h expected 1", mem_en); end
    @(negedge clk);
    d_req = 1'b0;
    @(negedge clk); #1;
    n_tests++; if (d_rvalid !== 1'b1) begin n_fail++; $display("FAIL load_rvalid: got %h expected 1", d_rvalid); end
    n_tests++; if (d_rdata !== 64'hA5A5_0000_FFFF_1234) begin n_fail++; $display("FAIL load_rdata: got %h expected a5a50000ffff1234", d_rdata); end
    n_tests++; if (d_err !== 1'b0) begin n_fail++; $display("FAIL load_err: got %h expected 0", d_err); end
    mem_rdata = 64'h0;
    @(negedge clk); #1;
    n_tests++; if (d_rdata !== 64'hA5A5_0000_FFFF_1234) begin n_fail++; $display("FAIL load_rdata_hold: got %h expected a5a50000ffff1234", d_rdata); end
  endtask

  task test_oor();
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h7FFF9; mem_rdata = 64'hDEADBEEF_12345678;
    #1;
    n_tests++; if (d_gnt !== 1'b1)  begin n_fail++; $display("FAIL oor_gnt: got %h expected 1", d_gnt); end
    n_tests++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL oor_mem_en: got %h expected 0", mem_en); end
    @(negedge clk);
    d_req = 1'b0;
    #1;
    n_tests++; if (d_err !== 1'b0)  begin n_fail++; $display("FAIL oor_err_early: got %h expected 0", d_err); end
    @(negedge clk); #1;
    n_tests++; if (d_rvalid !== 1'b1) begin n_fail++; $display("FAIL oor_rvalid: got %h expected 1", d_rvalid); end
    n_tests++; if (d_err !== 1'b1)  begin n_fail++; $display("FAIL oor_err: got %h expected 1", d_err); end
    n_tests++; if (d_rdata !== 64'd0) begin n_fail++; $display("FAIL oor_rdata: got %h expected 0", d_rdata); end
    @(negedge clk); #1;
    n_tests++; if (d_err !== 1'b0)  begin n_fail++; $display("FAIL oor_err_pulse: got %h expected 0", d_err); end
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'hFFFF_FFFC;
    #1;
    n_tests++; if (d_gnt !== 1'b1)  begin n_fail++; $display("FAIL wrap_gnt: got %h expected 1", d_gnt); end
    n_tests++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL wrap_mem_en: got %h expected 0", mem_en); end
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL wrap_mem_we: got %h expected 0", mem_we); end
    @(negedge clk);
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk); #1;
    n_tests++; if (d_err !== 1'b1)  begin n_fail++; $display("FAIL wrap_err: got %h expected 1", d_err); end
    @(negedge clk); #1;
  endtask

  task test_reset_mid();
    @(negedge clk);
    if_req = 1'b1; if_addr = 64'h3000;
    #1;
    n_tests++; if (if_gnt !== 1'b1) begin n_fail++; $display("FAIL rmid_gnt: got %h expected 1", if_gnt); end
    @(negedge clk);
    if_req = 1'b0; mem_rdata = 64'h0BAD_0BAD_CAFE_F00D;
    #1;
    reset = 1'b1;
    #1;
    n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rmid_busy: got %h expected 0", busy); end
    n_tests++; if (if_rvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_rvalid: got %h expected 0", if_rvalid); end
    n_tests++; if (if_rdata !== 32'd0) begin n_fail++; $display("FAIL rmid_rdata: got %h expected 0", if_rdata); end
    if_req = 1'b1; d_req = 1'b1;
    #1;
    n_tests++; if (if_gnt !== 1'b0)    begin n_fail++; $display("FAIL rmid_if_gnt_rst: got %h expected 0", if_gnt); end
    n_tests++; if (d_gnt !== 1'b0)     begin n_fail++; $display("FAIL rmid_d_gnt_rst: got %h expected 0", d_gnt); end
    n_tests++; if (mem_en !== 1'b0)    begin n_fail++; $display("FAIL rmid_mem_en: got %h expected 0", mem_en); end
    @(negedge clk);
    d_req = 1'b0;
    reset = 1'b0;
    #1;
    n_tests++; if (if_gnt !== 1'b1)    begin n_fail++; $display("FAIL rmid_regrant: got %h expected 1", if_gnt); end
    n_tests++; if (mem_addr !== 64'h3000) begin n_fail++; $display("FAIL rmid_addr: got %h expected 3000", mem_addr); end
    @(negedge clk);
    if_req = 1'b0;
    #1;
    n_tests++; if (if_rvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_no_stale: got %h expected 0", if_rvalid); end
    @(negedge clk); #1;
    n_tests++; if (if_rvalid !== 1'b1) begin n_fail++; $display("FAIL rmid_rvalid_new: got %h expected 1", if_rvalid); end
    n_tests++; if (if_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rmid_rdata_new: got %h expected cafef00d", if_rdata); end
    @(negedge clk); #1;
  endtask

  task test_hold_off();
    @(negedge clk);
    x_if_req = 1'b1;
    #1;
    n_tests++; if (x_if_gnt !== 1'b1) begin n_fail++; $display("FAIL hold_if_gnt: got %h expected 1", x_if_gnt); end
    @(negedge clk);
    x_if_req = 1'b0; x_d_req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      if (k != 1) @(negedge clk);
      #1;
      n_tests++;
      if (x_d_gnt !== 1'b0) begin n_fail++; $display("FAIL hold_d_gnt_early: cycle T+%0d got %h expected 0", k, x_d_gnt); end
    end
    @(negedge clk); #1;
    n_tests++; if (x_d_gnt !== 1'b1) begin n_fail++; $display("FAIL hold_d_gnt_t5: got %h expected 1", x_d_gnt); end
    @(negedge clk);
    x_d_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fetch();
    test_starve();
    test_store();
    test_load_boundary();
    test_oor();
    test_reset_mid();
    test_hold_off();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, meaning cycles from mem_en to valid mem_rdata (range 1-15).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive data grants tolerated while fetch waits (range 1-15).
REQ-003 SHALL have parameter MEM_BYTES, default 524288, meaning size of the byte-addressed memory.
REQ-004 SHALL have port clk  in  1  rising-edge clock.
REQ-005 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports if_req  in  1  fetch request; if_addr  in  64  fetch byte address.
REQ-007 SHALL have ports if_gnt  out  1  fetch accepted; if_rvalid  out  1  fetch data valid; if_rdata  out  32  instruction word.
REQ-008 SHALL have ports d_req  in  1  data request; d_we  in  1  1 = store; d_addr  in  32  data byte address; d_wdata  in  64  store data.
REQ-009 SHALL have ports d_gnt  out  1  data accepted; d_rvalid  out  1  load data or store ack valid; d_rdata  out  64  load data; d_err  out  1  out-of-range access.
REQ-010 SHALL have ports mem_en  out  1; mem_we  out  1; mem_addr  out  64; mem_wdata  out  64; mem_rdata  in  64.
REQ-011 SHALL have port busy  out  1  high whenever state is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT, RESP, with one transaction outstanding at most.
REQ-013 SHALL, in IDLE with any request, assert exactly one of if_gnt/d_gnt combinationally in that cycle (T) and go to WAIT.
REQ-014 SHALL grant data over fetch, except that fetch wins when if_req is high and starve count equals STARVE_LIMIT.
REQ-015 SHALL increment starve count (saturating at STARVE_LIMIT) on each data grant made while if_req is high, and clear it on each fetch grant.
REQ-016 SHALL drive mem_en=1 and mem_addr, mem_we, mem_wdata from the granted requester in cycle T only; at all other times mem_en and mem_we SHALL be 0.
REQ-017 SHALL drive mem_we=0 for fetches and mem_we=d_we for data.
REQ-018 SHALL flag a data request out of range when d_addr+7 >= MEM_BYTES (computed without 32-bit wrap), still grant it, keep mem_en=0, and set d_err=1 with its d_rvalid.
REQ-019 SHALL register mem_rdata at the end of cycle T+MEM_LAT, then enter RESP for cycle T+MEM_LAT+1.
REQ-020 SHALL, in RESP, pulse the granted requester's rvalid for one cycle, then return to IDLE; the next grant can occur no earlier than cycle T+MEM_LAT+2.
REQ-021 SHALL set if_rdata=mem_rdata[31:0], d_rdata=mem_rdata for loads, and d_rdata=0 for stores and errored accesses.
REQ-022 SHALL hold rdata outputs stable until the next rvalid; d_err SHALL be asserted only together with d_rvalid.
REQ-023 SHALL ignore requests in WAIT and RESP (gnt=0); requesters SHALL hold req until granted.
REQ-024 SHALL ignore a request that drops before its grant cycle, without side effects.

Reset
REQ-025 SHALL on reset force state IDLE, set starve count 0, and drive all outputs to 0 immediately, without waiting for a clock edge.
REQ-026 SHALL abort any transaction on reset mid-operation, with no rvalid produced for it after reset is released.
REQ-027 SHALL accept a grant in the first clock cycle after reset deasserts.

Verification
REQ-028 SHALL cover: MEM_LAT=1, if_req with if_addr=0x2000, mem_rdata=0xDEADBEEF_12345678 -> if_gnt in cycle 0, if_rvalid in cycle 2 with if_rdata=0x12345678.
REQ-029 SHALL cover: if_req and d_req held high continuously, STARVE_LIMIT=4 -> grant sequence D,D,D,D,IF,D,D,D,D,IF.
REQ-030 SHALL cover: store with d_addr=0x100, d_wdata=0x0123456789ABCDEF -> mem_en=mem_we=1, mem_addr=0x100 in grant cycle; d_rvalid=1 with d_rdata=0, d_err=0 at MEM_LAT+1 after grant.
REQ-031 SHALL cover: load with d_addr=0x7FFF9 -> d_gnt=1, mem_en=0, then d_rvalid=1 with d_err=1 and d_rdata=0.
REQ-032 SHALL cover: reset pulsed while in WAIT -> busy, gnt, rvalid and mem_en go to 0 asynchronously; no rvalid follows; a new request is granted in the first cycle after release.
REQ-033 SHALL cover: d_req raised during WAIT/RESP, MEM_LAT=3 -> d_gnt=0 until IDLE, then granted exactly at cycle T+5.
